// File: rtl/fetch_queue.sv
// Instruction fetch queue: owns the fetch PC, drives IMEM and buffers {pc, inst} entries for ID.
// Latency: an instruction pushed at edge N is presented first-word-fall-through on id_* in cycle N+1.
// Backpressure: id_ready low lets the queue fill to DEPTH, then fetch_pc holds; a flush drops all entries.
module fetch_queue #(
   parameter int unsigned PC_LENGTH   = 32,
   parameter int unsigned INST_LENGTH = 32,
   // Must be a power of two and at least 2 so the pointers wrap naturally.
   parameter int unsigned DEPTH       = 4,
   parameter logic [PC_LENGTH-1:0]   RESET_PC = '0,
   parameter logic [INST_LENGTH-1:0] NOP_INST = INST_LENGTH'(32'h0000_0013)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic [PC_LENGTH-1:0]         redirect_pc,
   output logic [PC_LENGTH-1:0]         imem_addr,
   input  logic [INST_LENGTH-1:0]       imem_inst,
   input  logic                         id_ready,
   output logic                         id_valid,
   output logic [INST_LENGTH-1:0]       id_inst,
   output logic [PC_LENGTH-1:0]         id_pc,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   // Architectural state
   logic [PC_LENGTH-1:0]   fetch_pc_q, fetch_pc_d;
   logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]          count_q, count_d;

   // Entry storage; contents are never reset, occupancy is tracked by count_q
   logic [PC_LENGTH-1:0]   pc_mem_q   [DEPTH];
   logic [INST_LENGTH-1:0] inst_mem_q [DEPTH];

   logic full;
   logic empty;
   logic push;
   logic pop;

   // Flags come from the registered count only, so a fetch never bypasses to ID in the same cycle
   always_comb begin
      full  = (count_q == CW'(DEPTH));
      empty = (count_q == '0);
      push  = !full && !flush;
      pop   = !empty && id_ready && !flush;
   end

   // Next-state: a redirect discards everything and restarts fetch at the word-aligned target
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      if (flush) begin
         fetch_pc_d = {redirect_pc[PC_LENGTH-1:2], 2'b00};
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (push) begin
            fetch_pc_d = fetch_pc_q + PC_LENGTH'(4);
            wr_ptr_d   = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         if (push && !pop) begin
            count_d = count_q + CW'(1);
         end else if (pop && !push) begin
            count_d = count_q - CW'(1);
         end
      end
   end

   // Control state register with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // Capture the fetched word together with the PC it came from
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
         inst_mem_q[wr_ptr_q] <= imem_inst;
      end
   end

   // Head outputs fall through from the read pointer; an empty queue shows a NOP at PC 0
   always_comb begin
      imem_addr = fetch_pc_q;
      id_valid  = !empty;
      count     = count_q;
      id_inst   = NOP_INST;
      id_pc     = '0;
      if (!empty) begin
         id_inst = inst_mem_q[rd_ptr_q];
         id_pc   = pc_mem_q[rd_ptr_q];
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with an IMEM model that returns inst = addr.
// Stimulus pushes the PCs it expects ID to accept; a negedge monitor pops and compares on each handshake.
// Direct checks of count/flags/addr are made 1 ns after the rising edge.
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic [31:0] redirect_pc;
   logic [31:0] imem_addr;
   logic [31:0] imem_inst;
   logic        id_ready;
   logic        id_valid;
   logic [31:0] id_inst;
   logic [31:0] id_pc;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q [$];

   fetch_queue #(
      .PC_LENGTH(32), .INST_LENGTH(32), .DEPTH(4),
      .RESET_PC(32'h0), .NOP_INST(32'h0000_0013)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush), .redirect_pc(redirect_pc),
      .imem_addr(imem_addr), .imem_inst(imem_inst), .id_ready(id_ready),
      .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc), .count(count)
   );

   // Combinational IMEM: each word holds its own address
   assign imem_inst = imem_addr;

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      check("sb_drain", 32'(exp_q.size()), 32'd0);
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   // Monitor: every accepted head must match the next expected PC, inst = PC
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (!rst && id_valid && id_ready && !flush) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL pop_unexpected: got pc 0x%0h expected no handshake at %0t", id_pc, $time);
            end else begin
               e = exp_q.pop_front();
               check("pop_pc", id_pc, e);
               check("pop_inst", id_inst, e);
            end
         end
      end
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; flush = 1'b0; redirect_pc = '0; id_ready = 1'b0;
      #1;
      check("rst_valid", 32'(id_valid), 32'd0);
      check("rst_inst", id_inst, 32'h13);
      check("rst_pc", id_pc, 32'h0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_addr", imem_addr, 32'h0);

      // Streaming with id_ready high: one per cycle, count stays 1
      id_ready = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 7; i++) exp_q.push_back(32'(4 * i));
      for (int i = 0; i < 8; i++) begin
         step();
         check("stream_count", 32'(count), 32'd1);
         check("stream_pc", id_pc, 32'(4 * i));
      end
      id_ready = 1'b0;

      // Fill with id_ready low, then drain
      apply_reset();
      for (int i = 1; i <= 4; i++) begin
         step();
         check("fill_count", 32'(count), 32'(i));
      end
      check("fill_addr", imem_addr, 32'h10);
      check("fill_head", id_pc, 32'h0);
      step();
      step();
      check("full_count", 32'(count), 32'd4);
      check("full_addr", imem_addr, 32'h10);
      check("full_head", id_pc, 32'h0);
      for (int i = 0; i < 8; i++) exp_q.push_back(32'(4 * i));
      id_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         check("drain_count", 32'(count), 32'd3);
      end
      id_ready = 1'b0;

      // Full with a single simultaneous pop: push resumes a cycle later
      step();
      check("refill_count", 32'(count), 32'd4);
      exp_q.push_back(32'h20);
      id_ready = 1'b1;
      step();
      id_ready = 1'b0;
      check("fullpop_count", 32'(count), 32'd3);
      check("fullpop_addr", imem_addr, 32'h30);
      step();
      check("fullpop_refill", 32'(count), 32'd4);
      check("fullpop_addr2", imem_addr, 32'h34);

      // Flush to a misaligned target while count=3, with id_ready high
      exp_q.push_back(32'h24);
      id_ready = 1'b1;
      step();
      id_ready = 1'b0;
      check("preflush_count", 32'(count), 32'd3);
      flush = 1'b1;
      redirect_pc = 32'h103;
      id_ready = 1'b1;
      step();
      flush = 1'b0;
      check("flush_count", 32'(count), 32'd0);
      check("flush_valid", 32'(id_valid), 32'd0);
      check("flush_inst", id_inst, 32'h13);
      check("flush_pc", id_pc, 32'h0);
      check("flush_addr", imem_addr, 32'h100);
      exp_q.push_back(32'h100);
      step();
      check("target_valid", 32'(id_valid), 32'd1);
      check("target_pc", id_pc, 32'h100);
      check("target_count", 32'(count), 32'd1);
      step();
      check("target_next", id_pc, 32'h104);
      id_ready = 1'b0;

      // Pointer wrap with id_ready toggling 1,0,1,0
      apply_reset();
      for (int i = 0; i < 10; i++) exp_q.push_back(32'(4 * i));
      for (int i = 0; i < 22; i++) begin
         id_ready = (i % 2 == 0);
         step();
      end
      id_ready = 1'b0;
      check("wrap_count", 32'(count), 32'd4);
      check("wrap_head", id_pc, 32'h28);

      // Asynchronous reset mid-fill
      apply_reset();
      step();
      step();
      check("midfill_count", 32'(count), 32'd2);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async_valid", 32'(id_valid), 32'd0);
      check("async_count", 32'(count), 32'd0);
      check("async_addr", imem_addr, 32'h0);
      check("async_inst", id_inst, 32'h13);
      step();
      rst = 1'b0;
      id_ready = 1'b1;
      exp_q.push_back(32'h0);
      step();
      check("restart_valid", 32'(id_valid), 32'd1);
      check("restart_pc", id_pc, 32'h0);
      step();
      check("restart_next", id_pc, 32'h4);
      id_ready = 1'b0;
      check("sb_final", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
